// File: rtl/pu_mux_sched_pkg.sv
// Shared types and helpers for the pu_multiplexer transaction sequencer.
package pu_mux_sched_pkg;

  // Transaction phases: command wait, arg streaming, select, output capture, result hold.
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSel,
    StOut,
    StResp
  } state_e;

  // Mux capacity in args for a given select width.
  function automatic int unsigned nmax(input int unsigned sel_width);
    return 32'd1 << sel_width;
  endfunction

endpackage

// File: rtl/pu_multiplexer_sched.sv
// Transaction sequencer for one pu_multiplexer: takes a command, streams its args into the mux,
// issues select and output strobes, and holds the captured result under valid/ready.
// Optional feature: define PU_MUX_SCHED_TIMEOUT_EN to abort a LOAD that idles for TIMEOUT cycles.
module pu_multiplexer_sched
  import pu_mux_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = 1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [SEL_WIDTH:0]    cmd_nargs,
  input  logic [SEL_WIDTH-1:0]  cmd_sel,
  input  logic                  arg_valid,
  output logic                  arg_ready,
  input  logic [DATA_WIDTH-1:0] arg_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_err,
  output logic                  mux_rst,
  output logic                  mux_data_active,
  output logic                  mux_sel_active,
  output logic                  mux_out_active,
  output logic [DATA_WIDTH-1:0] mux_data_in,
  input  logic [DATA_WIDTH-1:0] mux_data_out
);

  localparam int unsigned         NMax  = nmax(SEL_WIDTH);
  localparam logic [SEL_WIDTH:0]  NMaxW = (SEL_WIDTH + 1)'(NMax);

  state_e                  state_q, state_d;
  logic [SEL_WIDTH:0]      nargs_q, cnt_q;
  logic [SEL_WIDTH-1:0]    sel_q;
  logic [DATA_WIDTH-1:0]   res_data_q;
  logic                    res_err_q, mux_rst_q;
  logic                    cmd_acc, arg_acc, res_acc, nargs_legal, last_arg;
  logic                    timeout_hit;

  assign cmd_acc     = cmd_valid & cmd_ready;
  assign arg_acc     = arg_valid & arg_ready;
  assign res_acc     = res_valid & res_ready;
  assign nargs_legal = (cmd_nargs != '0) && (cmd_nargs <= NMaxW);
  assign last_arg    = (cnt_q == nargs_q - 1'b1);

  assign mux_rst  = mux_rst_q;
  assign res_data = res_data_q;
  assign res_err  = res_err_q;

`ifdef PU_MUX_SCHED_TIMEOUT_EN
  localparam int unsigned ToBits = $clog2(TIMEOUT + 1);
  localparam int unsigned ToW    = (ToBits > 8) ? ToBits : 8;

  logic [ToW-1:0] idle_cnt_q;
  logic           timeout_q;

  assign timeout_hit = (state_q == StLoad) && !arg_valid && (idle_cnt_q == ToW'(TIMEOUT - 1));

  // Idle counter runs only while LOAD stalls; timeout_q marks the dummy OUT cycle that follows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if ((state_q == StLoad) && !arg_valid) idle_cnt_q <= idle_cnt_q + 1'b1;
      else                                   idle_cnt_q <= '0;
      if (timeout_hit)              timeout_q <= 1'b1;
      else if (state_q == StResp)   timeout_q <= 1'b0;
    end
  end
`else
  logic timeout_q;
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign timeout_q      = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next-state logic: one whole transaction at a time.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (cmd_acc) state_d = nargs_legal ? StLoad : StResp;
      StLoad: begin
        if (arg_acc && last_arg) state_d = StSel;
        else if (timeout_hit)    state_d = StOut;
      end
      StSel:  state_d = StOut;
      StOut:  state_d = StResp;
      StResp: if (res_acc) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake and mux strobe outputs; mux_data_in is zero whenever no strobe is high.
  always_comb begin
    cmd_ready       = 1'b0;
    arg_ready       = 1'b0;
    res_valid       = 1'b0;
    mux_data_active = 1'b0;
    mux_sel_active  = 1'b0;
    mux_out_active  = 1'b0;
    mux_data_in     = '0;
    unique case (state_q)
      StIdle: cmd_ready = !mux_rst_q;
      StLoad: begin
        arg_ready       = 1'b1;
        mux_data_active = arg_valid;
        mux_data_in     = arg_valid ? arg_data : '0;
      end
      StSel: begin
        mux_sel_active = 1'b1;
        mux_data_in    = DATA_WIDTH'(sel_q);
      end
      StOut:  mux_out_active = 1'b1;
      StResp: res_valid = 1'b1;
      default: ;
    endcase
  end

  // Command latch, arg counter, result capture; mux_rst drops on the first edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nargs_q    <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      mux_rst_q  <= 1'b1;
    end else begin
      mux_rst_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_acc) begin
            nargs_q <= cmd_nargs;
            sel_q   <= cmd_sel;
            cnt_q   <= '0;
            if (!nargs_legal) begin
              res_data_q <= '0;
              res_err_q  <= 1'b1;
            end
          end
        end
        StLoad: if (arg_acc) cnt_q <= cnt_q + 1'b1;
        StOut: begin
          if (timeout_q) begin
            res_data_q <= '0;
            res_err_q  <= 1'b1;
          end else begin
            res_data_q <= mux_data_out;
            res_err_q  <= ({1'b0, sel_q} >= nargs_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
